// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_pkg;

  typedef enum logic [1:0] {
    S_RESET = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2,
    S_DROP  = 2'd3
  } if_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } ifid_t;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;
  localparam logic [31:0] PC_STEP  = 32'd4;

  function automatic logic [31:0] pc_next(input logic [31:0] pc);
    return pc + PC_STEP;
  endfunction

endpackage

// File: rtl/if_perf_counter.sv
// Fetch/stall event counters for the fetch stage; free-running, wrap at 2^32.
module if_perf_counter (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_inc,
  input  logic        stall_inc,
  output logic [31:0] fetch_cnt,
  output logic [31:0] stall_cnt
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (fetch_inc) fetch_cnt <= fetch_cnt + 32'd1;
      if (stall_inc) stall_cnt <= stall_cnt + 32'd1;
    end
  end

endmodule

// File: rtl/if_fetch_stage.sv
// RV32 instruction-fetch stage: PC, single-outstanding imem request, IF/ID register.
// Define IF_PERF_CNT_EN to build the fetch/stall performance counters.
module if_fetch_stage
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_in,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        im_req,
  output logic [31:0] im_addr,
  input  logic        im_rvalid,
  input  logic [31:0] im_rdata,
  output logic [31:0] IF_Instraction_out,
  output logic [31:0] IF_PC_out,
  output logic        im_stall,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_stall_cnt
);

  if_state_e   state, state_d;
  logic [31:0] fetch_pc, fetch_pc_d;
  logic        req_d;
  logic [31:0] addr_d;
  ifid_t       ifid, ifid_d;
  ifid_t       hold, hold_d;

  always_comb begin
    state_d    = state;
    fetch_pc_d = fetch_pc;
    req_d      = 1'b0;
    addr_d     = im_addr;
    ifid_d     = ifid;
    hold_d     = hold;
    if (redirect) begin
      ifid_d     = '{pc: 32'h0, inst: NOP_INST};
      fetch_pc_d = redirect_pc;
      case (state)
        S_WAIT: begin
          if (im_rvalid) begin
            req_d  = 1'b1;
            addr_d = redirect_pc;
          end else begin
            state_d = S_DROP;
          end
        end
        S_DROP: begin
          // the stale return arriving now retires the old request
          if (im_rvalid) begin
            req_d   = 1'b1;
            addr_d  = redirect_pc;
            state_d = S_WAIT;
          end
        end
        default: begin
          req_d   = 1'b1;
          addr_d  = redirect_pc;
          state_d = S_WAIT;
        end
      endcase
    end else begin
      case (state)
        S_RESET: begin
          req_d   = 1'b1;
          addr_d  = fetch_pc;
          state_d = S_WAIT;
        end
        S_WAIT: begin
          if (im_rvalid) begin
            if (stall_in) begin
              hold_d  = '{pc: fetch_pc, inst: im_rdata};
              state_d = S_HOLD;
            end else begin
              ifid_d     = '{pc: fetch_pc, inst: im_rdata};
              fetch_pc_d = pc_next(fetch_pc);
              req_d      = 1'b1;
              addr_d     = pc_next(fetch_pc);
            end
          end
        end
        S_HOLD: begin
          if (!stall_in) begin
            ifid_d     = hold;
            fetch_pc_d = pc_next(fetch_pc);
            req_d      = 1'b1;
            addr_d     = pc_next(fetch_pc);
            state_d    = S_WAIT;
          end
        end
        S_DROP: begin
          if (im_rvalid) begin
            req_d   = 1'b1;
            addr_d  = fetch_pc;
            state_d = S_WAIT;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_RESET;
      fetch_pc <= RESET_PC;
      im_req   <= 1'b0;
      im_addr  <= RESET_PC;
      ifid     <= '{pc: 32'h0, inst: NOP_INST};
      hold     <= '{pc: 32'h0, inst: NOP_INST};
    end else begin
      state    <= state_d;
      fetch_pc <= fetch_pc_d;
      im_req   <= req_d;
      im_addr  <= addr_d;
      ifid     <= ifid_d;
      hold     <= hold_d;
    end
  end

  assign IF_PC_out          = ifid.pc;
  assign IF_Instraction_out = ifid.inst;

  // S_HOLD and a return cycle both deliver, so neither stalls the pipeline
  assign im_stall = ~redirect & ((state == S_WAIT & ~im_rvalid) |
                                 (state == S_DROP) | (state == S_RESET));

`ifdef IF_PERF_CNT_EN
  logic fetch_load;
  assign fetch_load = ~redirect & ~stall_in &
                      ((state == S_WAIT & im_rvalid) | (state == S_HOLD));

  if_perf_counter u_perf (
    .clk       (clk),
    .rst       (rst),
    .fetch_inc (fetch_load),
    .stall_inc (im_stall),
    .fetch_cnt (perf_fetch_cnt),
    .stall_cnt (perf_stall_cnt)
  );
`else
  assign perf_fetch_cnt = '0;
  assign perf_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: variable-latency imem responder plus a flag-based
// transaction model of the fetch rules; directed scenarios then random traffic.
module tb_if_fetch_stage;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_in, redirect;
  logic [31:0] redirect_pc;
  logic        im_req;
  logic [31:0] im_addr;
  logic        im_rvalid;
  logic [31:0] im_rdata;
  logic [31:0] IF_Instraction_out, IF_PC_out;
  logic        im_stall;
  logic [31:0] perf_fetch_cnt, perf_stall_cnt;

  if_fetch_stage #(.RESET_PC(RST_PC)) dut (
    .clk                (clk),
    .rst                (rst),
    .stall_in           (stall_in),
    .redirect           (redirect),
    .redirect_pc        (redirect_pc),
    .im_req             (im_req),
    .im_addr            (im_addr),
    .im_rvalid          (im_rvalid),
    .im_rdata           (im_rdata),
    .IF_Instraction_out (IF_Instraction_out),
    .IF_PC_out          (IF_PC_out),
    .im_stall           (im_stall),
    .perf_fetch_cnt     (perf_fetch_cnt),
    .perf_stall_cnt     (perf_stall_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // imem responder
  int          lat = 1;
  int          mem_cnt = 0;
  logic [31:0] mem_addr = '0;

  // reference model
  logic        m_started, m_wait, m_discard, m_held, m_req;
  logic [31:0] m_pc, m_held_inst, m_ifpc, m_ifinst, m_addr, m_fcnt, m_scnt;
  logic        exp_stall, obs_stall;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return a ^ 32'h5A5A_0F00;
  endfunction

  task automatic model_reset();
    m_started = 1'b0; m_wait = 1'b0; m_discard = 1'b0; m_held = 1'b0;
    m_req = 1'b0; m_pc = RST_PC; m_addr = RST_PC;
    m_ifpc = 32'h0; m_ifinst = NOP; m_held_inst = NOP;
    m_fcnt = '0; m_scnt = '0;
  endtask

  task automatic m_issue(input logic [31:0] a);
    m_req = 1'b1; m_addr = a; m_wait = 1'b1; m_discard = 1'b0;
  endtask

  task automatic m_flush(input logic [31:0] rpc);
    m_ifpc = 32'h0; m_ifinst = NOP; m_pc = rpc;
  endtask

  task automatic model_clock(input bit st, input bit rd, input bit rv, input logic [31:0] rdat);
    m_req = 1'b0;
    if (!rst) model_reset();
    else begin
      if (exp_stall) m_scnt = m_scnt + 1;
      if (!m_started) begin
        m_started = 1'b1;
        if (rd) m_flush(redirect_pc);
        m_issue(m_pc);
      end else if (m_held) begin
        if (rd) begin
          m_flush(redirect_pc); m_held = 1'b0; m_issue(m_pc);
        end else if (!st) begin
          m_ifpc = m_pc; m_ifinst = m_held_inst; m_fcnt = m_fcnt + 1;
          m_pc = m_pc + 4; m_held = 1'b0; m_issue(m_pc);
        end
      end else if (m_discard) begin
        if (rd) m_flush(redirect_pc);
        if (rv) m_issue(m_pc);
      end else begin
        if (rd) begin
          m_flush(redirect_pc);
          if (rv) m_issue(m_pc);
          else    m_discard = 1'b1;
        end else if (rv) begin
          if (st) begin
            m_held = 1'b1; m_held_inst = rdat; m_wait = 1'b0;
          end else begin
            m_ifpc = m_pc; m_ifinst = rdat; m_fcnt = m_fcnt + 1;
            m_pc = m_pc + 4; m_issue(m_pc);
          end
        end
      end
    end
  endtask

  // One clock: drive inputs at the falling edge, sample im_stall, advance model.
  task automatic step(input bit st, input bit rd, input logic [31:0] rpc);
    logic        rv;
    logic [31:0] rdat;
    if (!rst) model_reset();
    rv   = 1'b0;
    rdat = $urandom();
    if (mem_cnt > 0) begin
      mem_cnt--;
      if (mem_cnt == 0) begin
        rv   = 1'b1;
        rdat = inst_of(mem_addr);
      end
    end
    if (im_req && rst) begin
      mem_cnt  = lat;
      mem_addr = im_addr;
    end
    im_rvalid = rv; im_rdata = rdat;
    stall_in = st; redirect = rd; redirect_pc = rpc;
    exp_stall = !rd && (!m_started || m_discard || (m_wait && !rv));
    #1 obs_stall = im_stall;
    @(posedge clk);
    model_clock(st, rd, rv, rdat);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0; stall_in = 1'b0; redirect = 1'b0; redirect_pc = '0;
    im_rvalid = 1'b0; im_rdata = '0;
    model_reset();
    repeat (2) @(negedge clk);
    total++; if (im_req !== 1'b0) begin bad++; $display("FAIL rst_req got %b want 0", im_req); end
    total++; if (im_addr !== RST_PC) begin bad++; $display("FAIL rst_addr got %h want %h", im_addr, RST_PC); end
    total++; if (IF_Instraction_out !== NOP) begin bad++; $display("FAIL rst_inst got %h want %h", IF_Instraction_out, NOP); end
    total++; if (IF_PC_out !== 32'h0) begin bad++; $display("FAIL rst_pc got %h want 0", IF_PC_out); end
    total++; if (im_stall !== 1'b1) begin bad++; $display("FAIL rst_stall got %b want 1", im_stall); end
    total++; if (perf_fetch_cnt !== 32'h0) begin bad++; $display("FAIL rst_fcnt got %0d want 0", perf_fetch_cnt); end
    total++; if (perf_stall_cnt !== 32'h0) begin bad++; $display("FAIL rst_scnt got %0d want 0", perf_stall_cnt); end
  endtask

  task automatic test_fetch_l1();
    rst = 1'b1; lat = 1;
    step(0, 0, 0);
    total++; if (obs_stall !== 1'b1) begin bad++; $display("FAIL l1_first_stall got %b want 1", obs_stall); end
    total++; if (im_req !== 1'b1 || im_addr !== RST_PC) begin bad++; $display("FAIL l1_first_req got %b/%h want 1/%h", im_req, im_addr, RST_PC); end
    for (int k = 0; k < 2; k++) begin
      step(0, 0, 0);
      total++; if (obs_stall !== 1'b1 || im_req !== 1'b0) begin bad++; $display("FAIL l1_wait%0d got stall=%b req=%b want 1/0", k, obs_stall, im_req); end
      step(0, 0, 0);
      total++; if (obs_stall !== 1'b0) begin bad++; $display("FAIL l1_ret_stall%0d got %b want 0", k, obs_stall); end
      total++; if (IF_PC_out !== 32'(4*k) || IF_Instraction_out !== inst_of(32'(4*k))) begin bad++; $display("FAIL l1_ifid%0d got %h/%h want %h/%h", k, IF_PC_out, IF_Instraction_out, 32'(4*k), inst_of(32'(4*k))); end
      total++; if (im_req !== 1'b1 || im_addr !== 32'(4*k+4)) begin bad++; $display("FAIL l1_next%0d got %b/%h want 1/%h", k, im_req, im_addr, 32'(4*k+4)); end
    end
    step(0, 0, 0);
  endtask

  task automatic test_stall();
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0);
      total++; if (im_req !== 1'b0 || IF_PC_out !== 32'h4) begin bad++; $display("FAIL stall_hold%0d got req=%b pc=%h want 0/4", i, im_req, IF_PC_out); end
    end
    step(0, 0, 0);
    total++; if (IF_PC_out !== 32'h8 || IF_Instraction_out !== inst_of(32'h8)) begin bad++; $display("FAIL stall_release got %h/%h want 8/%h", IF_PC_out, IF_Instraction_out, inst_of(32'h8)); end
    total++; if (im_req !== 1'b1 || im_addr !== 32'hC) begin bad++; $display("FAIL stall_next got %b/%h want 1/c", im_req, im_addr); end
  endtask

  task automatic test_redirect();
    lat = 3;
    step(0, 0, 0);
    step(0, 0, 0);
    step(0, 1, 32'h100);
    total++; if (obs_stall !== 1'b0) begin bad++; $display("FAIL redir_stall got %b want 0", obs_stall); end
    total++; if (IF_Instraction_out !== NOP || IF_PC_out !== 32'h0 || im_req !== 1'b0) begin bad++; $display("FAIL redir_flush got %h/%h req=%b want %h/0 req=0", IF_PC_out, IF_Instraction_out, im_req, NOP); end
    step(0, 0, 0);
    total++; if (obs_stall !== 1'b1) begin bad++; $display("FAIL drop_stall got %b want 1", obs_stall); end
    total++; if (im_req !== 1'b1 || im_addr !== 32'h100 || IF_Instraction_out !== NOP) begin bad++; $display("FAIL drop_req got %b/%h inst=%h want 1/100 inst=%h", im_req, im_addr, IF_Instraction_out, NOP); end
    repeat (4) step(0, 0, 0);
    total++; if (IF_PC_out !== 32'h100 || IF_Instraction_out !== inst_of(32'h100)) begin bad++; $display("FAIL redir_target got %h/%h want 100/%h", IF_PC_out, IF_Instraction_out, inst_of(32'h100)); end
    total++; if (im_req !== 1'b1 || im_addr !== 32'h104) begin bad++; $display("FAIL redir_next got %b/%h want 1/104", im_req, im_addr); end
  endtask

  task automatic test_redirect_rvalid();
    lat = 1;
    step(0, 0, 0);
    step(0, 1, 32'h200);
    total++; if (IF_Instraction_out !== NOP || IF_PC_out !== 32'h0) begin bad++; $display("FAIL rvred_flush got %h/%h want 0/%h", IF_PC_out, IF_Instraction_out, NOP); end
    total++; if (im_req !== 1'b1 || im_addr !== 32'h200) begin bad++; $display("FAIL rvred_req got %b/%h want 1/200", im_req, im_addr); end
    step(0, 0, 0);
    step(1, 0, 0);
    total++; if (im_req !== 1'b0 || IF_Instraction_out !== NOP) begin bad++; $display("FAIL hold_enter got req=%b inst=%h want 0/%h", im_req, IF_Instraction_out, NOP); end
    step(1, 1, 32'h300);
    total++; if (im_req !== 1'b1 || im_addr !== 32'h300 || IF_Instraction_out !== NOP) begin bad++; $display("FAIL holdred_req got %b/%h inst=%h want 1/300 inst=%h", im_req, im_addr, IF_Instraction_out, NOP); end
    step(0, 0, 0);
    step(0, 0, 0);
    total++; if (IF_PC_out !== 32'h300 || IF_Instraction_out !== inst_of(32'h300) || im_addr !== 32'h304) begin bad++; $display("FAIL holdred_target got %h/%h addr=%h want 300/%h addr=304", IF_PC_out, IF_Instraction_out, im_addr, inst_of(32'h300)); end
  endtask

  task automatic test_reset_midfetch();
    lat = 4;
    step(0, 0, 0);
    rst = 1'b0;
    #1;
    total++; if (im_req !== 1'b0 || IF_PC_out !== 32'h0 || IF_Instraction_out !== NOP) begin bad++; $display("FAIL async_rst got req=%b %h/%h want 0 0/%h", im_req, IF_PC_out, IF_Instraction_out, NOP); end
    repeat (3) step(0, 0, 0);
    rst = 1'b1;
    step(0, 0, 0);
    total++; if (im_req !== 1'b1 || im_addr !== RST_PC || IF_Instraction_out !== NOP) begin bad++; $display("FAIL late_ret got %b/%h inst=%h want 1/%h inst=%h", im_req, im_addr, IF_Instraction_out, RST_PC, NOP); end
    repeat (5) step(0, 0, 0);
    total++; if (IF_PC_out !== RST_PC || IF_Instraction_out !== inst_of(RST_PC)) begin bad++; $display("FAIL post_rst_fetch got %h/%h want %h/%h", IF_PC_out, IF_Instraction_out, RST_PC, inst_of(RST_PC)); end
  endtask

  task automatic test_perf();
    logic [31:0] ef, es;
    rst = 1'b0; mem_cnt = 0;
    #1;
    step(0, 0, 0);
    rst = 1'b1; lat = 2;
    repeat (31) step(0, 0, 0);
`ifdef IF_PERF_CNT_EN
    ef = 32'd10; es = 32'd21;
`else
    ef = 32'd0;  es = 32'd0;
`endif
    total++; if (perf_fetch_cnt !== ef) begin bad++; $display("FAIL perf_fetch got %0d want %0d", perf_fetch_cnt, ef); end
    total++; if (perf_stall_cnt !== es) begin bad++; $display("FAIL perf_stall got %0d want %0d", perf_stall_cnt, es); end
    total++; if (IF_PC_out !== 32'h24 || im_req !== 1'b1 || im_addr !== 32'h28) begin bad++; $display("FAIL perf_pc got pc=%h req=%b addr=%h want 24/1/28", IF_PC_out, im_req, im_addr); end
  endtask

  task automatic test_wrap();
    lat = 1;
    step(0, 1, 32'hFFFF_FFFC);
    step(0, 0, 0);
    total++; if (im_req !== 1'b1 || im_addr !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_req got %b/%h want 1/fffffffc", im_req, im_addr); end
    step(0, 0, 0);
    step(0, 0, 0);
    total++; if (IF_PC_out !== 32'hFFFF_FFFC || im_addr !== 32'h0) begin bad++; $display("FAIL wrap_pc got pc=%h addr=%h want fffffffc/0", IF_PC_out, im_addr); end
  endtask

  task automatic test_random();
    bit          st, rd;
    logic [31:0] rpc, ef, es;
    for (int n = 0; n < 600; n++) begin
      st  = ($urandom_range(0, 3) == 0);
      rd  = ($urandom_range(0, 15) == 0);
      rpc = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 : ($urandom() & 32'hFFFF_FFFC);
      lat = $urandom_range(1, 4);
      step(st, rd, rpc);
`ifdef IF_PERF_CNT_EN
      ef = m_fcnt; es = m_scnt;
`else
      ef = 32'd0;  es = 32'd0;
`endif
      total++; if (obs_stall !== exp_stall) begin bad++; $display("FAIL rnd_stall n=%0d got %b want %b", n, obs_stall, exp_stall); end
      total++; if (im_req !== m_req) begin bad++; $display("FAIL rnd_req n=%0d got %b want %b", n, im_req, m_req); end
      if (m_req) begin
        total++; if (im_addr !== m_addr) begin bad++; $display("FAIL rnd_addr n=%0d got %h want %h", n, im_addr, m_addr); end
      end
      total++; if (IF_PC_out !== m_ifpc) begin bad++; $display("FAIL rnd_pc n=%0d got %h want %h", n, IF_PC_out, m_ifpc); end
      total++; if (IF_Instraction_out !== m_ifinst) begin bad++; $display("FAIL rnd_inst n=%0d got %h want %h", n, IF_Instraction_out, m_ifinst); end
      total++; if (perf_fetch_cnt !== ef || perf_stall_cnt !== es) begin bad++; $display("FAIL rnd_perf n=%0d got %0d/%0d want %0d/%0d", n, perf_fetch_cnt, perf_stall_cnt, ef, es); end
    end
  endtask

  initial begin
    test_reset();
    test_fetch_l1();
    test_stall();
    test_redirect();
    test_redirect_rvalid();
    test_reset_midfetch();
    test_perf();
    test_wrap();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
